// File: rtl/pattern_serializer.sv
// Frames a parallel payload as sync pattern, MSB-first data and an idle gap, one bit per clk.
// Define SER_PARITY_EN to append an even-parity bit after the payload.
module pattern_serializer #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 DATA_W  = 8,
  parameter int                 GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              dout_bit,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_PD  = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GAP_LEN) ? MAX_PD : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef SER_PARITY_EN
    PAR,
`endif
    GAP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shreg;
  logic [PAT_LEN-1:0]  pat_q;
`ifdef SER_PARITY_EN
  logic                parity_q;
`endif

  assign din_ready = (state == IDLE);

  // Each output register holds the bit belonging to the state entered on the same edge,
  // so the first sync bit is visible in the cycle right after the handshake.
  // reset is active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      pat_q      <= '0;
      dout_bit   <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            state      <= SYNC;
            cnt        <= '0;
            shreg      <= din_data;
            pat_q      <= PATTERN << 1;
            dout_bit   <= PATTERN[PAT_LEN-1];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
`ifdef SER_PARITY_EN
            parity_q   <= ^din_data;
`endif
          end
        end
        SYNC: begin
          if (cnt == PAT_LAST) begin
            state    <= DATA;
            cnt      <= '0;
            dout_bit <= shreg[DATA_W-1];
            shreg    <= shreg << 1;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            dout_bit <= pat_q[PAT_LEN-1];
            pat_q    <= pat_q << 1;
          end
        end
        DATA: begin
          if (cnt == DATA_LAST) begin
`ifdef SER_PARITY_EN
            state      <= PAR;
            dout_bit   <= parity_q;
`else
            state      <= GAP;
            cnt        <= '0;
            dout_bit   <= 1'b0;
            dout_valid <= 1'b0;
            frame_done <= 1'b1;
`endif
          end else begin
            cnt      <= cnt + CNT_W'(1);
            dout_bit <= shreg[DATA_W-1];
            shreg    <= shreg << 1;
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          state      <= GAP;
          cnt        <= '0;
          dout_bit   <= 1'b0;
          dout_valid <= 1'b0;
          frame_done <= 1'b1;
        end
`endif
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: expected frame bits are queued at each
// handshake and popped as the serial stream appears.
module tb_pattern_serializer;

  localparam int              PAT_LEN = 4;
  localparam logic [3:0]      PATTERN = 4'b1011;
  localparam int              DATA_W  = 8;
  localparam int              GAP_LEN = 2;
`ifdef SER_PARITY_EN
  localparam int              PAR_BITS = 1;
`else
  localparam int              PAR_BITS = 0;
`endif
  localparam int              FRAME_BITS = PAT_LEN + DATA_W + PAR_BITS;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] din_data = '0;
  logic              din_ready;
  logic              dout_bit;
  logic              dout_valid;
  logic              busy;
  logic              frame_done;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic exp_q[$];

  pattern_serializer #(
    .PAT_LEN(PAT_LEN),
    .PATTERN(PATTERN),
    .DATA_W (DATA_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din_data  (din_data),
    .din_ready (din_ready),
    .dout_bit  (dout_bit),
    .dout_valid(dout_valid),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of one frame's valid bits, queued in transmission order.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [PAT_LEN-1:0] pat;
    pat = PATTERN;
    for (int i = PAT_LEN - 1; i >= 0; i--) exp_q.push_back(pat[i]);
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    for (int i = 0; i < 3; i++) begin
      #7;
      obs = {din_ready, busy, dout_valid, dout_bit, frame_done};
      compared++;
      if (obs !== 5'b10000) begin
        mismatched++;
        $display("[TB] FAIL reset_hold%0d: got rdy/busy/vld/bit/done=%b want 10000", i, obs);
      end
    end
    #4 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      obs = {din_ready, busy, dout_valid, dout_bit, frame_done};
      compared++;
      if (obs !== 5'b10000) begin
        mismatched++;
        $display("[TB] FAIL reset_release: got rdy/busy/vld/bit/done=%b want 10000", obs);
      end
    end
  endtask

  task automatic test_single_frame();
    int   busy_cycles = 0;
    int   done_pulses = 0;
    int   valid_cycles = 0;
    logic exp;
    @(negedge clk);
    compared++;
    if (din_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_ready: got %b want 1", din_ready);
    end
    din_valid = 1'b1;
    din_data  = 8'hA5;
    @(posedge clk);
    push_frame(8'hA5);
    for (int i = 0; i < FRAME_BITS + GAP_LEN + 1; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (busy === 1'b1) busy_cycles++;
      if (frame_done === 1'b1) done_pulses++;
      if (dout_valid === 1'b1) valid_cycles++;
      if (i < FRAME_BITS) begin
        exp = exp_q.pop_front();
        compared++;
        if (dout_valid !== 1'b1 || dout_bit !== exp) begin
          mismatched++;
          $display("[TB] FAIL single_bit%0d: got vld=%b bit=%b want vld=1 bit=%b", i, dout_valid, dout_bit, exp);
        end
      end else if (i == FRAME_BITS) begin
        compared++;
        if (frame_done !== 1'b1 || dout_valid !== 1'b0 || dout_bit !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL single_gap0: got done=%b vld=%b bit=%b want 1 0 0", frame_done, dout_valid, dout_bit);
        end
      end
    end
    compared++;
    if (busy_cycles != FRAME_BITS + GAP_LEN) begin
      mismatched++;
      $display("[TB] FAIL single_busy_len: got %0d want %0d", busy_cycles, FRAME_BITS + GAP_LEN);
    end
    compared++;
    if (done_pulses != 1) begin
      mismatched++;
      $display("[TB] FAIL single_done_count: got %0d want 1", done_pulses);
    end
    compared++;
    if (valid_cycles != FRAME_BITS) begin
      mismatched++;
      $display("[TB] FAIL single_valid_len: got %0d want %0d", valid_cycles, FRAME_BITS);
    end
  endtask

  task automatic test_back_to_back();
    int   first_sync0 = 0;
    int   first_sync1 = 0;
    logic exp;
    @(negedge clk);
    din_valid = 1'b1;
    din_data  = 8'h3C;
    @(posedge clk);
    push_frame(8'h3C);
    for (int i = 0; i < FRAME_BITS + GAP_LEN; i++) begin
      @(negedge clk);
      if (i == 0) begin
        first_sync0 = cyc;
        din_data = 8'hC3;
      end
      compared++;
      if (din_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL b2b_ready_f0_%0d: got %b want 0", i, din_ready);
      end
      if (i < FRAME_BITS) begin
        exp = exp_q.pop_front();
        compared++;
        if (dout_valid !== 1'b1 || dout_bit !== exp) begin
          mismatched++;
          $display("[TB] FAIL b2b_f0_bit%0d: got vld=%b bit=%b want vld=1 bit=%b", i, dout_valid, dout_bit, exp);
        end
      end
    end
    @(negedge clk);
    compared++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle: got rdy=%b vld=%b want 1 0", din_ready, dout_valid);
    end
    @(posedge clk);
    push_frame(8'hC3);
    for (int i = 0; i < FRAME_BITS + GAP_LEN + 1; i++) begin
      @(negedge clk);
      if (i == 0) begin
        first_sync1 = cyc;
        din_valid = 1'b0;
      end
      if (i < FRAME_BITS) begin
        exp = exp_q.pop_front();
        compared++;
        if (dout_valid !== 1'b1 || dout_bit !== exp || din_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL b2b_f1_bit%0d: got vld=%b bit=%b rdy=%b want 1 %b 0", i, dout_valid, dout_bit, din_ready, exp);
        end
      end
    end
    compared++;
    if (first_sync1 - first_sync0 != FRAME_BITS + GAP_LEN + 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_period: got %0d want %0d", first_sync1 - first_sync0, FRAME_BITS + GAP_LEN + 1);
    end
  endtask

  task automatic test_ignored_request();
    logic exp;
    @(negedge clk);
    din_valid = 1'b1;
    din_data  = 8'h00;
    @(posedge clk);
    push_frame(8'h00);
    for (int i = 0; i < FRAME_BITS + GAP_LEN + 1; i++) begin
      @(negedge clk);
      if (i < FRAME_BITS) begin
        exp = exp_q.pop_front();
        compared++;
        if (dout_valid !== 1'b1 || dout_bit !== exp) begin
          mismatched++;
          $display("[TB] FAIL ignore_bit%0d: got vld=%b bit=%b want vld=1 bit=%b", i, dout_valid, dout_bit, exp);
        end
      end
      if (i == 0) din_valid = 1'b0;
      if (i == PAT_LEN + 1) begin
        compared++;
        if (din_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL ignore_ready: got %b want 0", din_ready);
        end
        din_valid = 1'b1;
        din_data  = 8'hFF;
      end
      if (i == PAT_LEN + 2) din_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (dout_valid !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL ignore_no_frame%0d: got vld=%b busy=%b want 0 0", i, dout_valid, busy);
      end
    end
    din_data = 8'h00;
  endtask

  task automatic test_reset_mid_frame();
    logic       exp;
    logic [4:0] obs;
    int         done_pulses = 0;
    @(negedge clk);
    din_valid = 1'b1;
    din_data  = 8'h5A;
    @(posedge clk);
    push_frame(8'h5A);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      exp = exp_q.pop_front();
      compared++;
      if (dout_valid !== 1'b1 || dout_bit !== exp) begin
        mismatched++;
        $display("[TB] FAIL abort_bit%0d: got vld=%b bit=%b want vld=1 bit=%b", i, dout_valid, dout_bit, exp);
      end
    end
    #2 reset = 1'b0;
    #1;
    obs = {din_ready, busy, dout_valid, dout_bit, frame_done};
    compared++;
    if (obs !== 5'b10000) begin
      mismatched++;
      $display("[TB] FAIL abort_async: got rdy/busy/vld/bit/done=%b want 10000", obs);
    end
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (frame_done === 1'b1) done_pulses++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (frame_done === 1'b1) done_pulses++;
    compared++;
    if (done_pulses != 0) begin
      mismatched++;
      $display("[TB] FAIL abort_no_done: got %0d pulses want 0", done_pulses);
    end
    din_valid = 1'b1;
    din_data  = 8'h96;
    @(posedge clk);
    push_frame(8'h96);
    for (int i = 0; i < FRAME_BITS + GAP_LEN + 1; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (frame_done === 1'b1) done_pulses++;
      if (i < FRAME_BITS) begin
        exp = exp_q.pop_front();
        compared++;
        if (dout_valid !== 1'b1 || dout_bit !== exp) begin
          mismatched++;
          $display("[TB] FAIL after_abort_bit%0d: got vld=%b bit=%b want vld=1 bit=%b", i, dout_valid, dout_bit, exp);
        end
      end
    end
    compared++;
    if (done_pulses != 1) begin
      mismatched++;
      $display("[TB] FAIL after_abort_done: got %0d pulses want 1", done_pulses);
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    logic [DATA_W-1:0] d;
    logic              want_par;
    logic              exp;
    int                valid_cycles;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h07 : 8'h03;
      want_par = (f == 0) ? 1'b1 : 1'b0;
      valid_cycles = 0;
      @(negedge clk);
      din_valid = 1'b1;
      din_data  = d;
      @(posedge clk);
      push_frame(d);
      for (int i = 0; i < FRAME_BITS + GAP_LEN + 1; i++) begin
        @(negedge clk);
        din_valid = 1'b0;
        if (dout_valid === 1'b1) valid_cycles++;
        if (i < FRAME_BITS) begin
          exp = exp_q.pop_front();
          compared++;
          if (dout_valid !== 1'b1 || dout_bit !== exp) begin
            mismatched++;
            $display("[TB] FAIL parity_f%0d_bit%0d: got vld=%b bit=%b want vld=1 bit=%b", f, i, dout_valid, dout_bit, exp);
          end
        end
        if (i == FRAME_BITS - 1) begin
          compared++;
          if (dout_bit !== want_par) begin
            mismatched++;
            $display("[TB] FAIL parity_bit_f%0d: got %b want %b", f, dout_bit, want_par);
          end
        end
      end
      compared++;
      if (valid_cycles != 13) begin
        mismatched++;
        $display("[TB] FAIL parity_len_f%0d: got %0d want 13", f, valid_cycles);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_request();
    test_reset_mid_frame();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
